uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write/status bundle for uart_tx_fifo: byte enqueue strobe in, serial line and FIFO status out.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       DATA_IN;
  logic             DATA_WR;
  logic             TXD;
  logic             TX_BUSY;
  logic             FIFO_FULL;
  logic             FIFO_EMPTY;
  logic [CNT_W-1:0] FIFO_COUNT;
  logic             OVERFLOW;

  modport master (
    output DATA_IN, DATA_WR,
    input  TXD, TX_BUSY, FIFO_FULL, FIFO_EMPTY, FIFO_COUNT, OVERFLOW
  );

  modport slave (
    input  DATA_IN, DATA_WR,
    output TXD, TX_BUSY, FIFO_FULL, FIFO_EMPTY, FIFO_COUNT, OVERFLOW
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (start, 8 data bits MSB first, stop) fed by a small byte FIFO.
module uart_tx_fifo #(
  parameter int BIT_CYCLES = 8,
  parameter int DEPTH      = 4
) (
  input logic           CLK,
  input logic           RST_N,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic               wr_en;
  logic               pop;
  logic               fifo_nonempty;
  logic               cyc_done;

  // Next-state: FSM, FIFO pointers/count, and the registered line outputs.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    cyc_done      = (cyc_cnt_q == '0);
    wr_en         = bus.DATA_WR && (count_q < CNT_MAX);
    ovf_d         = bus.DATA_WR && (count_q >= CNT_MAX);
    pop           = 1'b0;
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    cyc_cnt_d     = cyc_cnt_q;

    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 4'd8;
          cyc_cnt_d = CYC_LAST;
          state_d   = START;
        end
      end
      START: begin
        if (cyc_done) begin
          cyc_cnt_d = CYC_LAST;
          state_d   = DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cyc_done) begin
          cyc_cnt_d = CYC_LAST;
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd1) state_d = STOP;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cyc_done) begin
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = 4'd8;
            cyc_cnt_d = CYC_LAST;
            state_d   = START;
          end else begin
            cyc_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);

    // Line outputs are computed from the next state so they are registered yet aligned with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[7];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.DATA_IN;
  end

  assign bus.TXD        = txd_q;
  assign bus.TX_BUSY    = busy_q;
  assign bus.OVERFLOW   = ovf_q;
  assign bus.FIFO_COUNT = count_q;
  assign bus.FIFO_FULL  = (count_q == CNT_MAX);
  assign bus.FIFO_EMPTY = (count_q == '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-position model, serial receiver, directed scenarios.
module tb_uart_tx_fifo;
  localparam int BC    = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BC;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.BIT_CYCLES(BC), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: pending-byte queue plus position inside the frame currently on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = '0;
  bit         m_ovf    = 1'b0;

  function automatic logic exp_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / BC;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[8 - idx];
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    int pre;
    if (!RST_N) begin
      if (m_active) void'(m_sent.pop_back());
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      pre   = m_q.size();
      m_ovf = 1'b0;
      if (m_active && m_pos < FRAME - 1) begin
        m_pos++;
      end else if (pre > 0) begin
        m_cur    = m_q.pop_front();
        m_pos    = 0;
        m_active = 1'b1;
        m_sent.push_back(m_cur);
      end else begin
        m_active = 1'b0;
      end
      if (bus.DATA_WR) begin
        if (pre < DEPTH) m_q.push_back(bus.DATA_IN);
        else             m_ovf = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    check("txd",   bus.TXD,        exp_txd());
    check("busy",  bus.TX_BUSY,    m_active);
    check("count", bus.FIFO_COUNT, m_q.size());
    check("full",  bus.FIFO_FULL,  m_q.size() == DEPTH);
    check("empty", bus.FIFO_EMPTY, m_q.size() == 0);
    check("ovf",   bus.OVERFLOW,   m_ovf);
  end

  // Serial receiver: mid-bit sampling; frames cut by reset are discarded.
  logic [7:0] rx_q[$];
  int         rx_n = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && bus.TXD === 1'b0) begin
        logic [9:0] bits;
        bit ok;
        ok   = 1'b1;
        bits = '0;
        for (int j = 0; j <= 76; j++) begin
          if (j > 0) @(negedge CLK);
          if (!RST_N) ok = 1'b0;
          if (j % 8 == 4) bits = {bits[8:0], bus.TXD};
        end
        if (ok) begin
          check("rx_start", bits[9], 1'b0);
          check("rx_stop",  bits[0], 1'b1);
          if (rx_n < m_sent.size()) check("rx_byte", bits[8:1], m_sent[rx_n]);
          else                      check("rx_extra", rx_n, m_sent.size());
          rx_q.push_back(bits[8:1]);
          rx_n++;
        end
      end
    end
  end

  // Writes n consecutive bytes base, base+1, ...; returns on the negedge after the last write edge.
  task automatic write_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.DATA_IN = base + 8'(i);
      bus.DATA_WR = 1'b1;
    end
    @(negedge CLK);
    bus.DATA_WR = 1'b0;
    bus.DATA_IN = 8'($urandom);
  endtask

  initial begin
    logic [9:0] seq;
    int busy_n, falls, ovf_n, low_n, base;
    logic prev_busy;

    bus.DATA_IN = '0;
    bus.DATA_WR = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_txd",   bus.TXD,        1'b1);
    check("rst_busy",  bus.TX_BUSY,    1'b0);
    check("rst_count", bus.FIFO_COUNT, 0);
    check("rst_empty", bus.FIFO_EMPTY, 1'b1);
    check("rst_full",  bus.FIFO_FULL,  1'b0);
    check("rst_ovf",   bus.OVERFLOW,   1'b0);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("idle_txd", bus.TXD, 1'b1);

    // Single 0xA5 frame: line still high right after the write edge, then 80 busy cycles.
    write_n(1, 8'hA5);
    check("a5_lat_txd",   bus.TXD,        1'b1);
    check("a5_lat_count", bus.FIFO_COUNT, 1);
    seq    = '0;
    busy_n = 0;
    for (int j = 0; j < 90; j++) begin
      @(negedge CLK);
      if (j < FRAME && j % 8 == 4) seq = {seq[8:0], bus.TXD};
      busy_n += int'(bus.TX_BUSY);
    end
    check("a5_bits", seq,    10'b0101001011);
    check("a5_busy", busy_n, 80);
    repeat (10) @(negedge CLK);

    // 0x3C through the receiver.
    write_n(1, 8'h3C);
    repeat (90) @(negedge CLK);
    check("3c_rxn",  rx_q.size(), 2);
    check("3c_byte", rx_q[1],     8'h3C);

    // Five bytes back-to-back: busy from the first pop edge for 400 contiguous cycles.
    base = rx_q.size();
    write_n(5, 8'h01);
    check("b2b_count", bus.FIFO_COUNT, 4);
    check("b2b_full",  bus.FIFO_FULL,  1'b1);
    busy_n    = 0;
    falls     = 0;
    ovf_n     = 0;
    prev_busy = bus.TX_BUSY;
    for (int j = 0; j < 420; j++) begin
      @(negedge CLK);
      busy_n += int'(bus.TX_BUSY);
      ovf_n  += int'(bus.OVERFLOW);
      if (prev_busy && !bus.TX_BUSY) falls++;
      prev_busy = bus.TX_BUSY;
    end
    // 4 busy cycles already elapsed before this window opened.
    check("b2b_busy",  busy_n, 396);
    check("b2b_falls", falls,  1);
    check("b2b_ovf",   ovf_n,  0);
    check("b2b_rxn",   rx_q.size(), base + 5);
    for (int i = 0; i < 5; i++) check("b2b_order", rx_q[base + i], 8'(i + 1));

    // Overflow: FIFO full with a frame on the line, 0xFF dropped.
    base = rx_q.size();
    write_n(5, 8'h10);
    check("ovf_pre_count", bus.FIFO_COUNT, 4);
    write_n(1, 8'hFF);
    check("ovf_pulse", bus.OVERFLOW,   1'b1);
    check("ovf_count", bus.FIFO_COUNT, 4);
    @(negedge CLK);
    check("ovf_clear", bus.OVERFLOW, 1'b0);
    repeat (5 * FRAME) @(negedge CLK);
    check("ovf_rxn", rx_q.size(), base + 5);
    for (int i = 0; i < 5; i++) check("ovf_order", rx_q[base + i], 8'h10 + 8'(i));

    // Write on the same edge as the STOP->START pop with two bytes queued.
    base = rx_q.size();
    write_n(3, 8'h41);
    repeat (78) @(negedge CLK);
    bus.DATA_IN = 8'h44;
    bus.DATA_WR = 1'b1;
    @(negedge CLK);
    bus.DATA_WR = 1'b0;
    check("pop_wr_count", bus.FIFO_COUNT, 2);
    check("pop_wr_txd",   bus.TXD,        1'b0);
    repeat (4 * FRAME + 20) @(negedge CLK);
    check("pop_wr_rxn", rx_q.size(), base + 4);
    for (int i = 0; i < 4; i++) check("pop_wr_order", rx_q[base + i], 8'h41 + 8'(i));

    // Reset 35 cycles into a frame with two bytes queued.
    base = rx_q.size();
    write_n(3, 8'h61);
    repeat (34) @(negedge CLK);
    check("mid_busy_pre", bus.TX_BUSY, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_txd",   bus.TXD,        1'b1);
    check("mid_rst_empty", bus.FIFO_EMPTY, 1'b1);
    check("mid_rst_busy",  bus.TX_BUSY,    1'b0);
    check("mid_rst_count", bus.FIFO_COUNT, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    low_n = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge CLK);
      low_n += int'(!bus.TXD);
    end
    check("post_rst_low", low_n,       0);
    check("post_rst_rxn", rx_q.size(), base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
